// File: rtl/ulpb_sleep_pkg.sv
// Shared types and defaults for the ULPB sleep-request controller.
package ulpb_sleep_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DELAY  = 3'd1,
    REQ    = 3'd2,
    ASLEEP = 3'd3,
    WAKE   = 3'd4
  } state_t;

  localparam int unsigned WAKE_HOLD_DEF = 4;

endpackage

// File: rtl/ulpb_sync2.sv
// Parameterised-width two-flop synchronizer with async active-low reset.
module ulpb_sync2 #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ulpb_sleep_req_ctrl.sv
// Delays and handshakes bus sleep commands into SLEEP_REQ and latches
// layer interrupts as WAKEUP_REQ for the MBus master sleep controller.
module ulpb_sleep_req_ctrl
  import ulpb_sleep_pkg::*;
#(
  parameter int unsigned NUM_INT     = 3,
  parameter int unsigned SLEEP_DLY_W = 8,
  parameter int unsigned WAKE_HOLD   = WAKE_HOLD_DEF
) (
  input  logic                   CLK,
  input  logic                   RESETn,
  input  logic                   SLEEP_CMD,
  input  logic [SLEEP_DLY_W-1:0] SLEEP_DLY,
  input  logic [NUM_INT-1:0]     INT_REQ,
  input  logic                   MBC_SLEEP,
  output logic                   SLEEP_REQ,
  output logic [NUM_INT-1:0]     WAKEUP_REQ,
  output logic                   SLEEP_CANCEL,
  output logic                   BUSY
);

  localparam int unsigned       HCNT_W    = 8;
  localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(WAKE_HOLD - 1);

  logic [NUM_INT-1:0]     int_s;
  logic [NUM_INT-1:0]     int_s_d;
  logic [NUM_INT-1:0]     int_rise;
  logic                   slp_s;

  state_t                 state, state_nxt;
  logic [SLEEP_DLY_W-1:0] cnt, cnt_nxt;
  logic [HCNT_W-1:0]      hcnt, hcnt_nxt;
  logic [NUM_INT-1:0]     pend, pend_nxt;
  logic                   cancel_nxt;

  ulpb_sync2 #(.W(NUM_INT)) u_sync_int (
    .clk   (CLK),
    .rst_n (RESETn),
    .d     (INT_REQ),
    .q     (int_s)
  );

  ulpb_sync2 #(.W(1)) u_sync_slp (
    .clk   (CLK),
    .rst_n (RESETn),
    .d     (MBC_SLEEP),
    .q     (slp_s)
  );

  assign int_rise = int_s & ~int_s_d;

  // Next-state, counter and pending-interrupt logic.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    hcnt_nxt   = hcnt;
    pend_nxt   = pend | int_rise;
    cancel_nxt = 1'b0;
    case (state)
      IDLE: begin
        pend_nxt = '0;
        if (SLEEP_CMD) begin
          if (|int_s) begin
            cancel_nxt = 1'b1;
          end else if (SLEEP_DLY == '0) begin
            state_nxt = REQ;
          end else begin
            state_nxt = DELAY;
            cnt_nxt   = SLEEP_DLY;
          end
        end
      end
      DELAY: begin
        // An interrupt during the delay aborts the sleep, even on the last count.
        if (|int_rise) begin
          state_nxt  = IDLE;
          cancel_nxt = 1'b1;
          pend_nxt   = '0;
          cnt_nxt    = '0;
        end else if (cnt == SLEEP_DLY_W'(1)) begin
          state_nxt = REQ;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - SLEEP_DLY_W'(1);
        end
      end
      REQ: begin
        if (|int_rise) begin
          state_nxt = WAKE;
          hcnt_nxt  = '0;
        end else if (slp_s) begin
          state_nxt = ASLEEP;
        end
      end
      ASLEEP: begin
        if (|int_rise) begin
          state_nxt = WAKE;
          hcnt_nxt  = '0;
        end else if (!slp_s) begin
          state_nxt = IDLE;
        end
      end
      WAKE: begin
        // Hold count only starts once the sleep controller has released MBC_SLEEP.
        if (slp_s) begin
          hcnt_nxt = '0;
        end else if (hcnt == HOLD_LAST) begin
          state_nxt = IDLE;
          pend_nxt  = '0;
          hcnt_nxt  = '0;
        end else begin
          hcnt_nxt = hcnt + HCNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        pend_nxt  = '0;
        cnt_nxt   = '0;
        hcnt_nxt  = '0;
      end
    endcase
  end

  // State, counters and registered Moore outputs.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state        <= IDLE;
      cnt          <= '0;
      hcnt         <= '0;
      pend         <= '0;
      int_s_d      <= '0;
      SLEEP_REQ    <= 1'b0;
      WAKEUP_REQ   <= '0;
      SLEEP_CANCEL <= 1'b0;
      BUSY         <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      hcnt         <= hcnt_nxt;
      pend         <= pend_nxt;
      int_s_d      <= int_s;
      SLEEP_REQ    <= (state_nxt == REQ);
      WAKEUP_REQ   <= (state_nxt == WAKE) ? pend_nxt : '0;
      SLEEP_CANCEL <= cancel_nxt;
      BUSY         <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_ulpb_sleep_req_ctrl.sv
// Directed self-checking bench for ulpb_sleep_req_ctrl.
module tb_ulpb_sleep_req_ctrl;

  logic       CLK = 1'b0;
  logic       RESETn;
  logic       SLEEP_CMD;
  logic [7:0] SLEEP_DLY;
  logic [2:0] INT_REQ;
  logic       MBC_SLEEP;
  logic       SLEEP_REQ;
  logic [2:0] WAKEUP_REQ;
  logic       SLEEP_CANCEL;
  logic       BUSY;

  int n_pass  = 0;
  int n_total = 0;
  logic [2:0] wake_seen;
  logic       req_seen;

  ulpb_sleep_req_ctrl dut (
    .CLK          (CLK),
    .RESETn       (RESETn),
    .SLEEP_CMD    (SLEEP_CMD),
    .SLEEP_DLY    (SLEEP_DLY),
    .INT_REQ      (INT_REQ),
    .MBC_SLEEP    (MBC_SLEEP),
    .SLEEP_REQ    (SLEEP_REQ),
    .WAKEUP_REQ   (WAKEUP_REQ),
    .SLEEP_CANCEL (SLEEP_CANCEL),
    .BUSY         (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
    wake_seen = wake_seen | WAKEUP_REQ;
    req_seen  = req_seen | SLEEP_REQ;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    RESETn    = 1'b0;
    SLEEP_CMD = 1'b0;
    SLEEP_DLY = 8'd0;
    INT_REQ   = 3'b000;
    MBC_SLEEP = 1'b0;
    wake_seen = '0;
    req_seen  = 1'b0;
    #3;
    chk("rst_sleep_req", 32'(SLEEP_REQ), 0);
    chk("rst_wakeup", 32'(WAKEUP_REQ), 0);
    chk("rst_cancel", 32'(SLEEP_CANCEL), 0);
    chk("rst_busy", 32'(BUSY), 0);
    ticks(2);
    RESETn = 1'b1;
    ticks(3);

    // Delay timing, ignored command, handshake into ASLEEP
    SLEEP_DLY = 8'd5; SLEEP_CMD = 1'b1; tick(); SLEEP_CMD = 1'b0;
    chk("dly_busy_e0", 32'(BUSY), 1);
    chk("dly_req_e0", 32'(SLEEP_REQ), 0);
    tick();
    SLEEP_DLY = 8'd0; SLEEP_CMD = 1'b1; tick(); SLEEP_CMD = 1'b0;
    chk("ign_cancel", 32'(SLEEP_CANCEL), 0);
    chk("ign_req", 32'(SLEEP_REQ), 0);
    ticks(2);
    chk("dly_req_e4", 32'(SLEEP_REQ), 0);
    tick();
    chk("dly_req_e5", 32'(SLEEP_REQ), 1);
    MBC_SLEEP = 1'b1;
    ticks(2);
    chk("req_hold", 32'(SLEEP_REQ), 1);
    tick();
    chk("asleep_req", 32'(SLEEP_REQ), 0);
    chk("asleep_busy", 32'(BUSY), 1);

    // Wake hold after interrupt in ASLEEP
    INT_REQ = 3'b010;
    ticks(2);
    chk("wake_pre", 32'(WAKEUP_REQ), 0);
    tick();
    chk("wake_set", 32'(WAKEUP_REQ), 32'b010);
    MBC_SLEEP = 1'b0;
    ticks(5);
    chk("wake_hold_last", 32'(WAKEUP_REQ), 32'b010);
    chk("wake_hold_busy", 32'(BUSY), 1);
    tick();
    chk("wake_done", 32'(WAKEUP_REQ), 0);
    chk("wake_done_busy", 32'(BUSY), 0);
    INT_REQ = 3'b000;
    ticks(4);

    // Cancel in DELAY
    req_seen = 1'b0; wake_seen = '0;
    SLEEP_DLY = 8'd20; SLEEP_CMD = 1'b1; tick(); SLEEP_CMD = 1'b0;
    ticks(6);
    INT_REQ = 3'b001;
    ticks(2);
    chk("cxl_pre", 32'(SLEEP_CANCEL), 0);
    chk("cxl_pre_busy", 32'(BUSY), 1);
    tick();
    chk("cxl_pulse", 32'(SLEEP_CANCEL), 1);
    chk("cxl_busy", 32'(BUSY), 0);
    tick();
    chk("cxl_one_cycle", 32'(SLEEP_CANCEL), 0);
    ticks(15);
    chk("cxl_no_req", 32'(req_seen), 0);
    chk("cxl_no_wake", 32'(wake_seen), 0);
    INT_REQ = 3'b000;
    ticks(4);

    // Reject in IDLE with interrupt already high
    INT_REQ = 3'b100;
    ticks(3);
    SLEEP_DLY = 8'd3; SLEEP_CMD = 1'b1; tick(); SLEEP_CMD = 1'b0;
    chk("rej_pulse", 32'(SLEEP_CANCEL), 1);
    chk("rej_busy", 32'(BUSY), 0);
    tick();
    chk("rej_one_cycle", 32'(SLEEP_CANCEL), 0);
    chk("rej_idle", 32'(BUSY), 0);
    INT_REQ = 3'b000;
    ticks(4);

    // Race in REQ: interrupt and sleep status rise together
    SLEEP_DLY = 8'd0; SLEEP_CMD = 1'b1; tick(); SLEEP_CMD = 1'b0;
    chk("race_req", 32'(SLEEP_REQ), 1);
    INT_REQ = 3'b001; MBC_SLEEP = 1'b1;
    ticks(2);
    chk("race_req_hold", 32'(SLEEP_REQ), 1);
    tick();
    chk("race_wake", 32'(WAKEUP_REQ), 32'b001);
    chk("race_req_drop", 32'(SLEEP_REQ), 0);
    MBC_SLEEP = 1'b0;
    ticks(5);
    chk("race_hold_last", 32'(WAKEUP_REQ), 32'b001);
    tick();
    chk("race_done", 32'(WAKEUP_REQ), 0);
    chk("race_idle", 32'(BUSY), 0);
    INT_REQ = 3'b000;
    ticks(4);

    // Asynchronous reset mid-WAKE
    SLEEP_CMD = 1'b1; tick(); SLEEP_CMD = 1'b0;
    INT_REQ = 3'b010;
    ticks(3);
    chk("rstw_wake", 32'(WAKEUP_REQ), 32'b010);
    #2 RESETn = 1'b0;
    #1;
    chk("rstw_wakeup", 32'(WAKEUP_REQ), 0);
    chk("rstw_busy", 32'(BUSY), 0);
    chk("rstw_req", 32'(SLEEP_REQ), 0);
    INT_REQ = 3'b000;
    ticks(2);
    RESETn = 1'b1;
    ticks(3);

    // Bus-initiated wake from ASLEEP without interrupt
    wake_seen = '0;
    SLEEP_CMD = 1'b1; tick(); SLEEP_CMD = 1'b0;
    MBC_SLEEP = 1'b1;
    ticks(3);
    chk("bus_asleep_req", 32'(SLEEP_REQ), 0);
    chk("bus_asleep_busy", 32'(BUSY), 1);
    MBC_SLEEP = 1'b0;
    ticks(2);
    chk("bus_still_busy", 32'(BUSY), 1);
    tick();
    chk("bus_idle", 32'(BUSY), 0);
    chk("bus_no_wake", 32'(wake_seen), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ulpb_sleep_req_ctrl.md
Name: ulpb_sleep_req_ctrl

Overview:
- Always-on stage directly upstream of the MBus master sleep controller.
- Turns a decoded bus sleep command into a delayed, handshaken SLEEP_REQ.
- Latches asynchronous layer interrupts as per-source WAKEUP_REQ lines, held until the sleep controller has released MBC_SLEEP.
- Cancels a pending sleep if an interrupt arrives before the sleep controller commits.

Parameters:
- NUM_INT, 3, number of interrupt/wakeup sources; bit i drives sleep controller WAKEUP_REQi.
- SLEEP_DLY_W, 8, width of the programmable sleep delay.
- WAKE_HOLD, 4, cycles WAKEUP_REQ stays high after MBC_SLEEP is seen low; range 1..255.

Ports:
- CLK  input  1  bus-controller clock.
- RESETn  input  1  asynchronous, active-low reset.
- SLEEP_CMD  input  1  one-cycle pulse; decoded broadcast sleep message.
- SLEEP_DLY  input  SLEEP_DLY_W  cycles from SLEEP_CMD to SLEEP_REQ; sampled with SLEEP_CMD.
- INT_REQ  input  NUM_INT  asynchronous layer interrupt levels.
- MBC_SLEEP  input  1  asynchronous sleep status from the sleep controller.
- SLEEP_REQ  output  1  to sleep controller SLEEP_REQ.
- WAKEUP_REQ  output  NUM_INT  to sleep controller WAKEUP_REQ0..NUM_INT-1.
- SLEEP_CANCEL  output  1  one-cycle pulse; sleep command rejected or aborted.
- BUSY  output  1  high whenever state is not IDLE.

Behaviour:
- Reset, asynchronous on RESETn low:
  - state IDLE; all outputs 0; counters, pending register and synchronizers 0.
  - Reset mid-operation drops SLEEP_REQ and WAKEUP_REQ the same instant.
- Synchronizers:
  - INT_REQ and MBC_SLEEP each pass a 2-flop synchronizer (int_s, slp_s).
  - int_rise = int_s & ~int_s_d (one extra flop per bit).
- Pending register pend[NUM_INT]:
  - sets on int_rise in DELAY, REQ, ASLEEP and WAKE;
  - clears on exit from WAKE; held 0 in IDLE.
- Outputs are Moore-decoded from registered state and registers:
  - SLEEP_REQ = (state == REQ).
  - WAKEUP_REQ = pend when state == WAKE, else 0.
- IDLE:
  - SLEEP_CMD & |int_s -> stay IDLE, pulse SLEEP_CANCEL.
  - SLEEP_CMD, SLEEP_DLY == 0 -> REQ.
  - SLEEP_CMD, SLEEP_DLY = N > 0 -> DELAY, cnt = N.
- DELAY:
  - |int_rise -> IDLE, SLEEP_CANCEL pulse, pend cleared. Cancel has priority over expiry.
  - else cnt == 1 -> REQ; otherwise cnt decrements.
- Timing: SLEEP_CMD sampled at edge E. SLEEP_REQ is visible after edge E+N, or after E when N = 0.
- REQ:
  - |int_rise -> WAKE. Wake has priority even if slp_s rises the same cycle.
  - else slp_s == 1 -> ASLEEP.
  - No timeout.
- ASLEEP (SLEEP_REQ = 0):
  - |int_rise -> WAKE.
  - else slp_s == 0 (bus-initiated wake via MBUS_DIN) -> IDLE.
- WAKE:
  - Holds hcnt = 0 while slp_s == 1.
  - Once slp_s == 0, increments hcnt each cycle.
  - When hcnt == WAKE_HOLD - 1 -> IDLE, pend cleared.
  - New int_rise during WAKE ORs into pend and is visible next cycle.
- SLEEP_CMD outside IDLE is ignored, with no cancel pulse.
- Counter widths: cnt is SLEEP_DLY_W bits; hcnt is 8 bits. No wrap possible given the transitions above.

Decomposition:
- Shared package ulpb_sleep_pkg: state enum (IDLE, DELAY, REQ, ASLEEP, WAKE), 3-bit encoding, WAKE_HOLD default constant.
- One sub-module: ulpb_sync2, a parameterised-width 2-flop synchronizer with async active-low reset. Instanced for INT_REQ and MBC_SLEEP.

Test Plan:
- Delay timing: SLEEP_DLY=5, SLEEP_CMD pulse at edge 10 -> SLEEP_REQ high from edge 15. Then MBC_SLEEP=1 -> ASLEEP within 3 edges, SLEEP_REQ=0, BUSY=1.
- Wake hold: in ASLEEP, INT_REQ[1] rises -> WAKEUP_REQ=3'b010 about 4 edges later. Drop MBC_SLEEP -> WAKEUP_REQ stays high 4 more cycles after slp_s low, then 0 and BUSY=0.
- Cancel in DELAY: SLEEP_DLY=20, INT_REQ[0] rises at delay cycle 7 -> one-cycle SLEEP_CANCEL, SLEEP_REQ never asserts, WAKEUP_REQ=0.
- Reject in IDLE: SLEEP_CMD while INT_REQ[2] already high -> SLEEP_CANCEL pulse, state stays IDLE.
- Race in REQ: SLEEP_DLY=0, int_rise and slp_s rise in the same cycle -> WAKE with WAKEUP_REQ nonzero; MBC_SLEEP later low -> IDLE after 4 cycles.
- Reset mid-op: RESETn low mid-WAKE -> all outputs 0 asynchronously. Bus-wake case: MBC_SLEEP falls in ASLEEP with no interrupt -> IDLE, WAKEUP_REQ never asserted.
